// File: rtl/ahb_master_burst_sequencer_pkg.sv
// Shared AHB-Lite types, burst-sequencer state encoding and burst length helper.
// Pure declarations: no timing or flow-control behaviour of its own.
package ahb_master_burst_sequencer_pkg;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } ahb_burst_e;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } ahb_trans_e;

    typedef enum logic [2:0] {
        SIZE_BYTE       = 3'd0,
        SIZE_HALFWORD   = 3'd1,
        SIZE_WORD       = 3'd2,
        SIZE_DOUBLEWORD = 3'd3,
        SIZE_4WORD      = 3'd4,
        SIZE_8WORD      = 3'd5,
        SIZE_16WORD     = 3'd6,
        SIZE_32WORD     = 3'd7
    } ahb_size_e;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } ahb_resp_e;

    typedef enum logic [1:0] {
        SEQ_IDLE      = 2'd0,
        SEQ_ADDR      = 2'd1,
        SEQ_BUSY      = 2'd2,
        SEQ_LAST_DATA = 2'd3
    } ahb_seq_state_e;

    localparam int unsigned KB_BOUNDARY = 1024;

    function automatic int unsigned burst_beats(ahb_burst_e burst, int unsigned len);
        case (burst)
            BURST_INCR:                 burst_beats = len;
            BURST_WRAP4,  BURST_INCR4:  burst_beats = 4;
            BURST_WRAP8,  BURST_INCR8:  burst_beats = 8;
            BURST_WRAP16, BURST_INCR16: burst_beats = 16;
            default:                    burst_beats = 1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_master_burst_sequencer_if.sv
// Request and AHB address-phase bundle between a burst sequencer (master) and its peer (slave).
// Wires only; hready/hresp stall and abort the master.
interface ahb_master_burst_sequencer_if
    import ahb_master_burst_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LENGTH     = 4
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH-1:0]   req_addr;
    ahb_burst_e              req_burst;
    ahb_size_e               req_size;
    logic                    req_write;
    logic [LENGTH:0]         req_len;
    logic [2**LENGTH-1:0]    req_busy_mask;
    logic [ADDR_WIDTH-1:0]   haddr;
    ahb_trans_e              htrans;
    ahb_burst_e              hburst;
    ahb_size_e               hsize;
    logic                    hwrite;
    logic                    hready;
    logic                    hresp;
    logic [LENGTH-1:0]       beat_idx;
    logic                    done;
    logic                    error;

    modport master (
        input  req_valid, req_addr, req_burst, req_size, req_write, req_len, req_busy_mask,
        input  hready, hresp,
        output req_ready, haddr, htrans, hburst, hsize, hwrite, beat_idx, done, error
    );

    modport slave (
        output req_valid, req_addr, req_burst, req_size, req_write, req_len, req_busy_mask,
        output hready, hresp,
        input  req_ready, haddr, htrans, hburst, hsize, hwrite, beat_idx, done, error
    );
endinterface

// File: rtl/ahb_master_burst_sequencer_addr_calc.sv
// Combinational next-beat address (INCR/WRAP) and whole-burst 1KB-crossing check.
// Zero latency, no flow control.
module ahb_master_burst_sequencer_addr_calc
    import ahb_master_burst_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LENGTH     = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  ahb_burst_e            burst,
    input  ahb_size_e             size,
    input  logic [LENGTH:0]       beats,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  crosses_1kb
);
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [31:0]           offs;
    logic [31:0]           span;
    logic                  is_wrap;

    always_comb begin
        inc       = ADDR_WIDTH'(1) << size;
        incr_addr = addr + inc;
        wrap_mask = (ADDR_WIDTH'(beats) << size) - ADDR_WIDTH'(1);
        is_wrap   = (burst == BURST_WRAP4) || (burst == BURST_WRAP8) || (burst == BURST_WRAP16);
        next_addr = is_wrap ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
        // Wrapping bursts stay inside their own aligned window, so only incrementing ones can cross.
        offs        = 32'(addr[9:0]);
        span        = 32'(beats) << size;
        crosses_1kb = !is_wrap && (burst != BURST_SINGLE) && ((offs + span) > KB_BOUNDARY);
    end
endmodule

// File: rtl/ahb_master_burst_sequencer.sv
// AHB-Lite address-phase engine: one validated burst at a time, beat 0 one cycle after accept.
// Advances only on hready=1; all bus outputs registered and held while hready=0.
module ahb_master_burst_sequencer
    import ahb_master_burst_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LENGTH     = 4
) (
    input  logic                        hclk,
    input  logic                        hreset,
    ahb_master_burst_sequencer_if.master bus
);
    localparam logic [2:0]      MAX_SIZE  = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [LENGTH:0] MAX_BEATS = (LENGTH + 1)'(2 ** LENGTH);

    ahb_seq_state_e        state_q, state_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    ahb_trans_e            htrans_q, htrans_d;
    ahb_burst_e            hburst_q, hburst_d;
    ahb_size_e             hsize_q, hsize_d;
    logic                  hwrite_q, hwrite_d;
    logic [LENGTH-1:0]     beat_idx_q, beat_idx_d;
    logic [LENGTH:0]       beats_q, beats_d;
    logic [2**LENGTH-1:0]  mask_q, mask_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  in_idle;
    logic [LENGTH:0]       req_beats;
    logic [ADDR_WIDTH-1:0] calc_addr, next_addr;
    ahb_burst_e            calc_burst;
    ahb_size_e             calc_size;
    logic [LENGTH:0]       calc_beats;
    logic                  crosses_1kb;
    logic                  misaligned, bad_len, reject;
    logic [LENGTH-1:0]     nxt_idx;
    logic                  is_last;

    // One calculator serves both jobs: request validation in IDLE, beat stepping otherwise.
    assign in_idle    = (state_q == SEQ_IDLE);
    assign req_beats  = (LENGTH + 1)'(burst_beats(bus.req_burst, 32'(bus.req_len)));
    assign calc_addr  = in_idle ? bus.req_addr  : haddr_q;
    assign calc_burst = in_idle ? bus.req_burst : hburst_q;
    assign calc_size  = in_idle ? bus.req_size  : hsize_q;
    assign calc_beats = in_idle ? req_beats     : beats_q;

    ahb_master_burst_sequencer_addr_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LENGTH     (LENGTH)
    ) u_addr_calc (
        .addr        (calc_addr),
        .burst       (calc_burst),
        .size        (calc_size),
        .beats       (calc_beats),
        .next_addr   (next_addr),
        .crosses_1kb (crosses_1kb)
    );

    assign misaligned = ((bus.req_addr & ((ADDR_WIDTH'(1) << bus.req_size) - ADDR_WIDTH'(1))) != '0);
    assign bad_len    = (bus.req_burst == BURST_INCR) && ((bus.req_len == '0) || (bus.req_len > MAX_BEATS));
    assign reject     = (3'(bus.req_size) > MAX_SIZE) || misaligned || crosses_1kb || bad_len;
    assign nxt_idx    = beat_idx_q + LENGTH'(1);
    assign is_last    = ({1'b0, beat_idx_q} == (beats_q - (LENGTH + 1)'(1)));

    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        htrans_d   = htrans_q;
        hburst_d   = hburst_q;
        hsize_d    = hsize_q;
        hwrite_d   = hwrite_q;
        beat_idx_d = beat_idx_q;
        beats_d    = beats_q;
        mask_d     = mask_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (bus.req_valid) begin
                    if (reject) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d    = SEQ_ADDR;
                        htrans_d   = TRANS_NONSEQ;
                        haddr_d    = bus.req_addr;
                        hburst_d   = bus.req_burst;
                        hsize_d    = bus.req_size;
                        hwrite_d   = bus.req_write;
                        beat_idx_d = '0;
                        beats_d    = req_beats;
                        mask_d     = bus.req_busy_mask;
                    end
                end
            end
            SEQ_ADDR: begin
                // First cycle of a two-cycle ERROR: cancel the pending address, wait out the data phase.
                if (!bus.hready && bus.hresp) begin
                    state_d  = SEQ_LAST_DATA;
                    htrans_d = TRANS_IDLE;
                end else if (bus.hready) begin
                    if (is_last) begin
                        state_d  = SEQ_LAST_DATA;
                        htrans_d = TRANS_IDLE;
                    end else begin
                        beat_idx_d = nxt_idx;
                        haddr_d    = next_addr;
                        if (mask_q[nxt_idx]) begin
                            state_d  = SEQ_BUSY;
                            htrans_d = TRANS_BUSY;
                        end else begin
                            htrans_d = TRANS_SEQ;
                        end
                    end
                end
            end
            SEQ_BUSY: begin
                if (!bus.hready && bus.hresp) begin
                    state_d  = SEQ_LAST_DATA;
                    htrans_d = TRANS_IDLE;
                end else if (bus.hready) begin
                    state_d  = SEQ_ADDR;
                    htrans_d = TRANS_SEQ;
                end
            end
            SEQ_LAST_DATA: begin
                if (bus.hready) begin
                    state_d = SEQ_IDLE;
                    done_d  = 1'b1;
                    error_d = bus.hresp;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= SEQ_IDLE;
            haddr_q    <= '0;
            htrans_q   <= TRANS_IDLE;
            hburst_q   <= BURST_SINGLE;
            hsize_q    <= SIZE_BYTE;
            hwrite_q   <= 1'b0;
            beat_idx_q <= '0;
            beats_q    <= '0;
            mask_q     <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            hburst_q   <= hburst_d;
            hsize_q    <= hsize_d;
            hwrite_q   <= hwrite_d;
            beat_idx_q <= beat_idx_d;
            beats_q    <= beats_d;
            mask_q     <= mask_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.req_ready = in_idle;
    assign bus.haddr     = haddr_q;
    assign bus.htrans    = htrans_q;
    assign bus.hburst    = hburst_q;
    assign bus.hsize     = hsize_q;
    assign bus.hwrite    = hwrite_q;
    assign bus.beat_idx  = beat_idx_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_ahb_master_burst_sequencer.sv
// Directed bench for the AHB burst sequencer: expected beats/completions are queued when a request
// is issued and a negedge monitor compares every non-IDLE address cycle and every done pulse.
module tb_ahb_master_burst_sequencer;
    import ahb_master_burst_sequencer_pkg::*;

    typedef struct packed {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [3:0]  idx;
        logic [2:0]  burst;
        logic [2:0]  size;
        logic        write;
    } beat_t;

    logic hclk = 1'b0;
    logic hreset;
    always #5 hclk = ~hclk;

    ahb_master_burst_sequencer_if #(.ADDR_WIDTH(32), .LENGTH(4)) ifc ();

    ahb_master_burst_sequencer #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .LENGTH     (4)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (ifc.master)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_before = 0;
    int         done_cyc = 0;
    int         last_acc_cyc = 0;
    beat_t      exp_q[$];
    logic       exp_done_q[$];
    ahb_burst_e cur_burst;
    ahb_size_e  cur_size;
    logic       cur_write;
    beat_t      act;
    logic       exp_err;

    always @(posedge hclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Monitor: every non-IDLE address cycle must equal the queue head; it retires on hready=1.
    always @(negedge hclk) begin
        if (ifc.htrans != TRANS_IDLE) begin
            act = '{trans: ifc.htrans, addr: ifc.haddr, idx: ifc.beat_idx,
                    burst: ifc.hburst, size: ifc.hsize, write: ifc.hwrite};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected actual=%0d/%h/%0d expected=none", act.trans, act.addr, act.idx);
            end else begin
                if (act !== exp_q[0]) begin
                    failures++;
                    $display("FAIL beat actual=%0d/%h/%0d/%0d/%0d/%0d expected=%0d/%h/%0d/%0d/%0d/%0d",
                             act.trans, act.addr, act.idx, act.burst, act.size, act.write,
                             exp_q[0].trans, exp_q[0].addr, exp_q[0].idx, exp_q[0].burst,
                             exp_q[0].size, exp_q[0].write);
                end
                if (ifc.hready) begin
                    last_acc_cyc = cyc;
                    void'(exp_q.pop_front());
                end
            end
        end
        if (ifc.done) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_done_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected actual=1 expected=0");
            end else begin
                exp_err = exp_done_q.pop_front();
                chk("done_error", 32'(ifc.error), 32'(exp_err));
            end
        end else if (ifc.error) begin
            checks++;
            failures++;
            $display("FAIL error_without_done actual=1 expected=0");
        end
    end

    task automatic set_ctx(input ahb_burst_e b, input ahb_size_e s, input logic w);
        cur_burst = b;
        cur_size  = s;
        cur_write = w;
    endtask

    task automatic exp_beat(input ahb_trans_e t, input logic [31:0] a, input int idx);
        beat_t b;
        b.trans = t;
        b.addr  = a;
        b.idx   = 4'(idx);
        b.burst = cur_burst;
        b.size  = cur_size;
        b.write = cur_write;
        exp_q.push_back(b);
    endtask

    task automatic push_incr(input logic [31:0] start, input int n, input int step);
        for (int i = 0; i < n; i++)
            exp_beat((i == 0) ? TRANS_NONSEQ : TRANS_SEQ, start + 32'(i * step), i);
    endtask

    // Called at posedge+1 with the sequencer idle; returns at posedge+1 after the accepting edge.
    task automatic send_req(input logic [31:0] a, input logic [4:0] len, input logic [15:0] mask);
        done_before       = done_cnt;
        ifc.req_addr      = a;
        ifc.req_burst     = cur_burst;
        ifc.req_size      = cur_size;
        ifc.req_write     = cur_write;
        ifc.req_len       = len;
        ifc.req_busy_mask = mask;
        ifc.req_valid     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge hclk);
            if (ifc.req_ready) break;
        end
        chk("req_ready", 32'(ifc.req_ready), 32'd1);
        @(posedge hclk);
        #1;
        ifc.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 100; i++) begin
            if (done_cnt != done_before) break;
            @(posedge hclk);
            #1;
        end
        chk(name, 32'(done_cnt != done_before), 32'd1);
        repeat (2) begin
            @(posedge hclk);
            #1;
        end
        chk("beats_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        hreset            = 1'b1;
        ifc.req_valid     = 1'b0;
        ifc.req_addr      = '0;
        ifc.req_burst     = BURST_SINGLE;
        ifc.req_size      = SIZE_BYTE;
        ifc.req_write     = 1'b0;
        ifc.req_len       = '0;
        ifc.req_busy_mask = '0;
        ifc.hready        = 1'b1;
        ifc.hresp         = 1'b0;
        repeat (3) @(posedge hclk);
        #1;
        hreset = 1'b0;

        chk("rst_htrans",    32'(ifc.htrans),    32'(TRANS_IDLE));
        chk("rst_haddr",     ifc.haddr,          32'h0);
        chk("rst_hburst",    32'(ifc.hburst),    32'(BURST_SINGLE));
        chk("rst_hsize",     32'(ifc.hsize),     32'(SIZE_BYTE));
        chk("rst_hwrite",    32'(ifc.hwrite),    32'd0);
        chk("rst_beat_idx",  32'(ifc.beat_idx),  32'd0);
        chk("rst_req_ready", 32'(ifc.req_ready), 32'd1);
        chk("rst_done",      32'(ifc.done),      32'd0);
        chk("rst_error",     32'(ifc.error),     32'd0);

        // INCR4 WORD at 0x100: 100/104/108/10C, then one IDLE (last data phase), then done.
        set_ctx(BURST_INCR4, SIZE_WORD, 1'b1);
        push_incr(32'h100, 4, 4);
        exp_done_q.push_back(1'b0);
        send_req(32'h100, 5'd0, 16'h0);
        wait_done("incr4_done");
        chk("incr4_done_lat", 32'(done_cyc - last_acc_cyc), 32'd2);

        set_ctx(BURST_WRAP4, SIZE_WORD, 1'b0);
        exp_beat(TRANS_NONSEQ, 32'h38, 0);
        exp_beat(TRANS_SEQ,    32'h3C, 1);
        exp_beat(TRANS_SEQ,    32'h30, 2);
        exp_beat(TRANS_SEQ,    32'h34, 3);
        exp_done_q.push_back(1'b0);
        send_req(32'h38, 5'd0, 16'h0);
        wait_done("wrap4_done");

        set_ctx(BURST_WRAP8, SIZE_HALFWORD, 1'b0);
        exp_beat(TRANS_NONSEQ, 32'h0E, 0);
        exp_beat(TRANS_SEQ,    32'h00, 1);
        exp_beat(TRANS_SEQ,    32'h02, 2);
        exp_beat(TRANS_SEQ,    32'h04, 3);
        exp_beat(TRANS_SEQ,    32'h06, 4);
        exp_beat(TRANS_SEQ,    32'h08, 5);
        exp_beat(TRANS_SEQ,    32'h0A, 6);
        exp_beat(TRANS_SEQ,    32'h0C, 7);
        exp_done_q.push_back(1'b0);
        send_req(32'h0E, 5'd0, 16'h0);
        wait_done("wrap8_done");

        // INCR8 with a BUSY before beat 3: nine address cycles, 0x10C shown as BUSY then SEQ.
        set_ctx(BURST_INCR8, SIZE_WORD, 1'b1);
        exp_beat(TRANS_NONSEQ, 32'h100, 0);
        exp_beat(TRANS_SEQ,    32'h104, 1);
        exp_beat(TRANS_SEQ,    32'h108, 2);
        exp_beat(TRANS_BUSY,   32'h10C, 3);
        exp_beat(TRANS_SEQ,    32'h10C, 3);
        exp_beat(TRANS_SEQ,    32'h110, 4);
        exp_beat(TRANS_SEQ,    32'h114, 5);
        exp_beat(TRANS_SEQ,    32'h118, 6);
        exp_beat(TRANS_SEQ,    32'h11C, 7);
        exp_done_q.push_back(1'b0);
        send_req(32'h100, 5'd0, 16'h0008);
        wait_done("busy_done");

        // Wait states on beat 1: the monitor re-checks the held beat on each stalled cycle.
        set_ctx(BURST_INCR4, SIZE_WORD, 1'b0);
        push_incr(32'h100, 4, 4);
        exp_done_q.push_back(1'b0);
        send_req(32'h100, 5'd0, 16'h0);
        @(posedge hclk);
        #1;
        ifc.hready = 1'b0;
        repeat (3) @(posedge hclk);
        #1;
        chk("hold_haddr", ifc.haddr, 32'h104);
        ifc.hready = 1'b1;
        wait_done("hold_done");

        // Two-cycle ERROR in beat 1's data phase: beat 2 is withdrawn, beat 3 never appears.
        set_ctx(BURST_INCR4, SIZE_WORD, 1'b1);
        push_incr(32'h200, 3, 4);
        exp_done_q.push_back(1'b1);
        send_req(32'h200, 5'd0, 16'h0);
        @(posedge hclk);
        #1;
        @(posedge hclk);
        #1;
        ifc.hready = 1'b0;
        ifc.hresp  = 1'b1;
        @(posedge hclk);
        #1;
        chk("err_htrans_idle", 32'(ifc.htrans), 32'(TRANS_IDLE));
        ifc.hready = 1'b1;
        @(posedge hclk);
        #1;
        ifc.hresp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_cnt != done_before) break;
            @(posedge hclk);
            #1;
        end
        chk("err_done", 32'(done_cnt != done_before), 32'd1);
        chk("err_beat2_unaccepted", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        repeat (2) @(posedge hclk);
        #1;

        // Rejected requests: done&error only, any bus activity trips the monitor.
        set_ctx(BURST_INCR16, SIZE_WORD, 1'b0);
        exp_done_q.push_back(1'b1);
        send_req(32'h3F0, 5'd0, 16'h0);
        wait_done("rej_1kb");

        set_ctx(BURST_SINGLE, SIZE_WORD, 1'b0);
        exp_done_q.push_back(1'b1);
        send_req(32'h102, 5'd0, 16'h0);
        wait_done("rej_unaligned");

        set_ctx(BURST_SINGLE, SIZE_DOUBLEWORD, 1'b0);
        exp_done_q.push_back(1'b1);
        send_req(32'h100, 5'd0, 16'h0);
        wait_done("rej_size");

        set_ctx(BURST_INCR, SIZE_WORD, 1'b0);
        exp_done_q.push_back(1'b1);
        send_req(32'h100, 5'd0, 16'h0);
        wait_done("rej_len0");

        // Ends exactly on the 1KB boundary, so it is legal.
        set_ctx(BURST_INCR4, SIZE_WORD, 1'b0);
        push_incr(32'h3F0, 4, 4);
        exp_done_q.push_back(1'b0);
        send_req(32'h3F0, 5'd0, 16'h0);
        wait_done("edge_1kb_done");

        set_ctx(BURST_INCR, SIZE_BYTE, 1'b1);
        exp_beat(TRANS_NONSEQ, 32'h41, 0);
        exp_done_q.push_back(1'b0);
        send_req(32'h41, 5'd1, 16'h0);
        wait_done("incr_len1_done");

        // Reset in the middle of INCR8: bus returns to reset values, no completion.
        set_ctx(BURST_INCR8, SIZE_WORD, 1'b0);
        push_incr(32'h300, 3, 4);
        send_req(32'h300, 5'd0, 16'h0);
        @(posedge hclk);
        #1;
        @(posedge hclk);
        #1;
        hreset = 1'b1;
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        chk("mid_rst_htrans",    32'(ifc.htrans),    32'(TRANS_IDLE));
        chk("mid_rst_haddr",     ifc.haddr,          32'h0);
        chk("mid_rst_req_ready", 32'(ifc.req_ready), 32'd1);
        repeat (5) @(posedge hclk);
        #1;
        chk("mid_rst_no_done", 32'(done_cnt), 32'(done_before));
        chk("mid_rst_beats",   32'(exp_q.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_done_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
